afu_rd_stream: RTL and testbench
================================

Name: afu_rd_stream

Overview:
- Core-side consumer of the afu_io read path, inside afu_core.
- Turns a (base address, line count) job into a sequence of cor_tx_rd requests.
- Accepts the returning io_rx_rd_valid/io_rx_data lines, buffers them, and presents them as a ready/valid stream to core compute logic.
- Because io_rx has no backpressure, buffer space is reserved by credit before any request is issued.

Parameters:
- MAX_BURST, 8, max cache lines per request (1..64).
- FIFO_DEPTH, 64, line buffer depth; power of two, >= MAX_BURST.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse; sampled only in IDLE
- base_addr  in  58  first cache-line address of the job
- num_lines  in  32  job length in cache lines
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when the job has completed
- overflow_err  out  1  sticky: a line arrived with no outstanding request
- spl_tx_rd_almostfull  in  1  read request path throttle
- cor_tx_rd_valid  out  1  read request strobe
- cor_tx_rd_addr  out  58  request cache-line address
- cor_tx_rd_len  out  6  request length in lines; 0 encodes 64
- io_rx_rd_valid  in  1  returned line strobe; lines return in request order
- io_rx_data  in  512  returned line
- out_valid  out  1  stream valid
- out_data  out  512  stream data
- out_ready  in  1  stream ready

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, FIFO empty. Reset mid-job abandons the job; later io_rx lines are counted as spurious (overflow_err).
- States:
  - IDLE: on start, latch base_addr/num_lines into cur_addr/remaining and go to ISSUE; if num_lines==0, go to FIN instead. start outside IDLE is ignored.
  - ISSUE: each cycle compute burst=min(remaining,MAX_BURST) and free=FIFO_DEPTH-fifo_count-outstanding. If !spl_tx_rd_almostfull && free>=burst, register a request for the next cycle:
    - cor_tx_rd_valid=1, cor_tx_rd_addr=cur_addr, cor_tx_rd_len=burst[5:0]
    - cur_addr+=burst, remaining-=burst, outstanding+=burst
    - Go to DRAIN when remaining reaches 0.
  - DRAIN: wait until outstanding==0 and the FIFO is empty, then go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Requests: at most one per cycle; cor_tx_rd_valid is high for exactly one cycle per request. almostfull is sampled in the issuing cycle, so a request already registered is not retracted.
- Return path: each io_rx_rd_valid with outstanding>0 writes io_rx_data into the FIFO and decrements outstanding.
  - If outstanding==0 in any state: line dropped, overflow_err set; it clears only on reset.
- Simultaneous issue and return in one cycle: outstanding_next = outstanding + burst - 1.
- Credit guarantees the FIFO never overflows: fifo_count + outstanding <= FIFO_DEPTH at all times.
- busy=1 in ISSUE and DRAIN, 0 otherwise.
- Output stream: FWFT. out_valid = FIFO non-empty; out_data is the head entry. Pop on out_valid&&out_ready. Write and read in the same cycle are both honoured.
- Latency:
  - start at edge N → first request visible after edge N+1.
  - io_rx_rd_valid at edge M → out_valid after edge M when the FIFO was empty.
  - Last pop at edge K → done after edge K+1, with DRAIN→FIN taken at edge K.
- Widths:
  - cur_addr wraps modulo 2^58, no error.
  - remaining is 32 bits.
  - outstanding and fifo_count are clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package afu_rd_pkg holds:
  - state enum t_rd_state (IDLE, ISSUE, DRAIN, FIN)
  - CL_ADDR_W=58, CL_DATA_W=512, RD_LEN_W=6
- One sub-module, afu_rd_fifo: synchronous FWFT FIFO parameterised by width and depth, exposing count, push, pop, empty.

Test Plan:
- num_lines=20, base=0x100, MAX_BURST=8, out_ready=1 → requests (0x100,8),(0x108,8),(0x110,4); 20 lines out in return order; one done pulse; busy falls with done.
- num_lines=64, MAX_BURST=64 → single request with len=0 at base; 64 lines out; done once.
- spl_tx_rd_almostfull held high 10 cycles after start → no cor_tx_rd_valid; on release, first request exactly one cycle later.
- FIFO_DEPTH=16, MAX_BURST=8, num_lines=40, out_ready=0 → exactly 16 lines requested, then stall; enable out_ready → remaining 24 issued, all 40 delivered, overflow_err=0.
- num_lines=0 → no requests; done pulse one cycle after start sampled; busy stays 0.
- io_rx_rd_valid in IDLE → overflow_err=1, out_valid stays 0. Then assert reset_n=0 mid-job with outstanding=5 → all outputs 0 immediately; a new start completes normally.

Source files
------------

// File: rtl/afu_rd_stream_pkg.sv
// Shared types and widths for the afu_io read-stream consumer.
// Holds the FSM state encoding, the bus widths and the burst sizing helper.
package afu_rd_pkg;

  localparam int CL_ADDR_W = 58;
  localparam int CL_DATA_W = 512;
  localparam int RD_LEN_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } t_rd_state;

  // Lines the next request may carry: whatever is left, capped at the burst limit.
  function automatic logic [31:0] burst_lines(input logic [31:0] remaining,
                                              input logic [31:0] max_burst);
    return (remaining < max_burst) ? remaining : max_burst;
  endfunction

endpackage

// File: rtl/afu_rd_stream_if.sv
// Read-request, read-return and output-stream signals of the read streamer.
// master is the streamer side; slave is the afu_io / compute side.
interface afu_rd_stream_if;
  import afu_rd_pkg::*;

  logic                 spl_tx_rd_almostfull;
  logic                 cor_tx_rd_valid;
  logic [CL_ADDR_W-1:0] cor_tx_rd_addr;
  logic [RD_LEN_W-1:0]  cor_tx_rd_len;
  logic                 io_rx_rd_valid;
  logic [CL_DATA_W-1:0] io_rx_data;
  logic                 out_valid;
  logic [CL_DATA_W-1:0] out_data;
  logic                 out_ready;

  modport master (
    input  spl_tx_rd_almostfull,
    output cor_tx_rd_valid,
    output cor_tx_rd_addr,
    output cor_tx_rd_len,
    input  io_rx_rd_valid,
    input  io_rx_data,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    output spl_tx_rd_almostfull,
    input  cor_tx_rd_valid,
    input  cor_tx_rd_addr,
    input  cor_tx_rd_len,
    output io_rx_rd_valid,
    output io_rx_data,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/afu_rd_stream_fifo.sv
// First-word-fall-through line buffer; head entry is visible whenever non-empty.
// Read data is forced to zero while empty so nothing stale leaks after reset.
module afu_rd_fifo
  import afu_rd_pkg::*;
#(
  parameter int WIDTH = CL_DATA_W,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (count == '0);
  assign wr_en    = push && (count != (AW+1)'(DEPTH));
  assign rd_en    = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/afu_rd_stream.sv
// Turns a (base address, line count) job into credit-gated read requests and
// streams the returned lines out through a FWFT buffer.
//
// state | meaning
// IDLE  | waiting for start; job parameters latched on start
// ISSUE | issuing bursts while buffer credit and the request path allow
// DRAIN | all requested; waiting for returns to land and the buffer to empty
// FIN   | job complete; done pulses on the following cycle
module afu_rd_stream
  import afu_rd_pkg::*;
#(
  parameter int MAX_BURST  = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CL_ADDR_W-1:0] base_addr,
  input  logic [31:0]          num_lines,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow_err,
  afu_rd_stream_if.master      bus
);

  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] MAX_LINES = 32'(MAX_BURST);

  t_rd_state            state;
  t_rd_state            state_next;
  logic [CL_ADDR_W-1:0] cur_addr;
  logic [31:0]          remaining;
  logic [CNT_W-1:0]     outstanding;

  logic [31:0]          burst;
  logic [CNT_W-1:0]     burst_cnt;
  logic [CNT_W-1:0]     free_cnt;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 issue;
  logic                 last_issue;
  logic                 rx_accept;
  logic                 rx_spurious;
  logic                 drain_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_lines == '0) ? FIN : ISSUE;
      ISSUE:   if (last_issue) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Credit counts lines already buffered plus lines still in flight, since
  // the return path cannot be stalled once a request has gone out.
  always_comb begin
    burst       = burst_lines(remaining, MAX_LINES);
    burst_cnt   = burst[CNT_W-1:0];
    free_cnt    = CNT_W'(FIFO_DEPTH) - fifo_count - outstanding;
    issue       = (state == ISSUE) && !bus.spl_tx_rd_almostfull && (free_cnt >= burst_cnt);
    last_issue  = issue && (remaining == burst);
    rx_accept   = bus.io_rx_rd_valid && (outstanding != '0);
    rx_spurious = bus.io_rx_rd_valid && (outstanding == '0);
    fifo_pop    = !fifo_empty && bus.out_ready;
    // Leaving DRAIN on the cycle of the final pop keeps done one cycle after it.
    drain_done  = (outstanding == '0) &&
                  (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr            <= '0;
      remaining           <= '0;
      outstanding         <= '0;
      overflow_err        <= 1'b0;
      bus.cor_tx_rd_valid <= 1'b0;
      bus.cor_tx_rd_addr  <= '0;
      bus.cor_tx_rd_len   <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        cur_addr  <= base_addr;
        remaining <= num_lines;
      end else if (issue) begin
        cur_addr  <= cur_addr + CL_ADDR_W'(burst);
        remaining <= remaining - burst;
      end
      outstanding <= outstanding + (issue ? burst_cnt : '0) - CNT_W'(rx_accept);
      if (rx_spurious) overflow_err <= 1'b1;
      bus.cor_tx_rd_valid <= issue;
      if (issue) begin
        bus.cor_tx_rd_addr <= cur_addr;
        bus.cor_tx_rd_len  <= burst[RD_LEN_W-1:0];
      end
      busy <= (state == ISSUE) || (state == DRAIN);
      done <= (state == FIN);
    end
  end

  afu_rd_fifo #(
    .WIDTH (CL_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rx_accept),
    .push_data (bus.io_rx_data),
    .pop       (fifo_pop),
    .pop_data  (bus.out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.out_valid = !fifo_empty;

endmodule

// File: tb/tb_afu_rd_stream.sv
// Scoreboard bench: dut1 (burst 8, depth 16) runs most jobs behind a line
// responder; dut2 (burst 64, depth 64) covers the len=0 encoding.
module tb_afu_rd_stream;

  typedef struct {
    logic [57:0] addr;
    logic [5:0]  len;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start1, start2;
  logic [57:0] base1, base2;
  logic [31:0] num1, num2;
  logic        busy1, done1, ovf1;
  logic        busy2, done2, ovf2;

  afu_rd_stream_if bus1 ();
  afu_rd_stream_if bus2 ();

  afu_rd_stream #(.MAX_BURST(8), .FIFO_DEPTH(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .base_addr(base1), .num_lines(num1),
    .busy(busy1), .done(done1), .overflow_err(ovf1), .bus(bus1));

  afu_rd_stream #(.MAX_BURST(64), .FIFO_DEPTH(64)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .base_addr(base2), .num_lines(num2),
    .busy(busy2), .done(done2), .overflow_err(ovf2), .bus(bus2));

  always #5 clk = ~clk;

  req_t         exp_req[$];
  logic [511:0] exp_data[$];
  logic [511:0] pending[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int req_lines = 0;
  int inject_cnt = 0;
  int inject_done = 0;
  bit resp_hold = 1'b0;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [511:0] line_of(input logic [57:0] a);
    return {8{a, 6'h15}};
  endfunction

  // dut1 monitor and line responder; everything is sampled mid-cycle.
  initial begin : mon
    int   len;
    req_t r;
    bus1.io_rx_rd_valid = 1'b0;
    bus1.io_rx_data     = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus1.cor_tx_rd_valid) begin
          len = (bus1.cor_tx_rd_len == 6'd0) ? 64 : int'(bus1.cor_tx_rd_len);
          req_lines += len;
          for (int i = 0; i < len; i++) pending.push_back(line_of(bus1.cor_tx_rd_addr + 58'(i)));
          if (exp_req.size() == 0) check("req_unexpected", 1, 0);
          else begin
            r = exp_req.pop_front();
            check("req_addr", bus1.cor_tx_rd_addr, r.addr);
            check("req_len", bus1.cor_tx_rd_len, r.len);
          end
        end
        if (bus1.out_valid && bus1.out_ready) begin
          if (exp_data.size() == 0) check("out_unexpected", 1, 0);
          else check("out_data", bus1.out_data, exp_data.pop_front());
        end
        if (done1) begin
          done_cnt++;
          check("busy_at_done", busy1, 0);
        end
      end
      bus1.io_rx_rd_valid = 1'b0;
      if (inject_cnt != inject_done) begin
        bus1.io_rx_rd_valid = 1'b1;
        bus1.io_rx_data     = {16{32'hDEAD_BEEF}};
        inject_done++;
      end else if (!resp_hold && pending.size() > 0) begin
        bus1.io_rx_rd_valid = 1'b1;
        bus1.io_rx_data     = pending.pop_front();
      end
    end
  end

  task automatic start_job(input logic [57:0] base, input logic [31:0] n);
    logic [31:0] rem;
    logic [57:0] a;
    int          b;
    rem = n;
    a   = base;
    while (rem > 0) begin
      b = (rem > 32'd8) ? 8 : int'(rem);
      exp_req.push_back('{a, 6'(b)});
      a   += 58'(b);
      rem -= 32'(b);
    end
    for (int i = 0; i < int'(n); i++) exp_data.push_back(line_of(base + 58'(i)));
    @(posedge clk); #1;
    base1  = base;
    num1   = n;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int c0, input string tag);
    for (int i = 0; i < 3000 && done_cnt == c0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check(tag, done_cnt - c0, 1);
    check({tag, "_req_left"}, exp_req.size(), 0);
    check({tag, "_data_left"}, exp_data.size(), 0);
  endtask

  initial begin : main
    int          c0;
    int          r0;
    int          got;
    int          sent;
    int          d2done;
    bit          seen;
    logic [511:0] q2[$];

    start1 = 1'b0; start2 = 1'b0;
    base1 = '0; base2 = '0; num1 = '0; num2 = '0;
    bus1.spl_tx_rd_almostfull = 1'b0; bus1.out_ready = 1'b1;
    bus2.spl_tx_rd_almostfull = 1'b0; bus2.out_ready = 1'b1;
    bus2.io_rx_rd_valid = 1'b0; bus2.io_rx_data = '0;

    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_ovf", ovf1, 0);
    check("rst_req_valid", bus1.cor_tx_rd_valid, 0);
    check("rst_out_valid", bus1.out_valid, 0);
    reset_n = 1'b1;

    // 20 lines from 0x100 in bursts of 8, 8, 4
    c0 = done_cnt;
    start_job(58'h100, 32'd20);
    check("t1_busy_early", busy1, 0);
    @(posedge clk); #1;
    check("t1_first_req", bus1.cor_tx_rd_valid, 1);
    wait_done(c0, "t1_done");
    check("t1_ovf", ovf1, 0);

    // request path throttled for 10 cycles after start
    bus1.spl_tx_rd_almostfull = 1'b1;
    c0 = done_cnt;
    r0 = req_lines;
    start_job(58'h400, 32'd10);
    repeat (10) @(posedge clk);
    #1;
    check("af_hold_lines", req_lines - r0, 0);
    check("af_hold_valid", bus1.cor_tx_rd_valid, 0);
    bus1.spl_tx_rd_almostfull = 1'b0;
    @(posedge clk); #1;
    check("af_release", bus1.cor_tx_rd_valid, 1);
    wait_done(c0, "af_done");

    // stalled consumer: credit limits in-flight + buffered lines to 16
    bus1.out_ready = 1'b0;
    c0 = done_cnt;
    r0 = req_lines;
    start_job(58'h800, 32'd40);
    repeat (80) @(posedge clk);
    #1;
    check("bp_lines", req_lines - r0, 16);
    check("bp_out_valid", bus1.out_valid, 1);
    bus1.out_ready = 1'b1;
    wait_done(c0, "bp_done");
    check("bp_total", req_lines - r0, 40);
    check("bp_ovf", ovf1, 0);

    // zero-length job: no requests, done one cycle after start is sampled
    c0 = done_cnt;
    r0 = req_lines;
    @(posedge clk); #1;
    num1 = 32'd0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("zero_done_early", done1, 0);
    check("zero_busy_a", busy1, 0);
    @(posedge clk); #1;
    check("zero_done", done1, 1);
    check("zero_busy_b", busy1, 0);
    @(posedge clk); #1;
    check("zero_done_off", done1, 0);
    check("zero_done_cnt", done_cnt - c0, 1);
    check("zero_reqs", req_lines - r0, 0);

    // dut2: a full 64-line burst encodes len as 0
    for (int i = 0; i < 64; i++) q2.push_back(line_of(58'h3_0000 + 58'(i)));
    @(posedge clk); #1;
    base2 = 58'h3_0000; num2 = 32'd64; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus2.cor_tx_rd_valid) seen = 1'b1;
    end
    check("d2_req_seen", seen, 1);
    check("d2_req_addr", bus2.cor_tx_rd_addr, 58'h3_0000);
    check("d2_req_len", bus2.cor_tx_rd_len, 6'd0);
    got = 0; sent = 0; d2done = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus2.cor_tx_rd_valid) check("d2_extra_req", 1, 0);
      if (bus2.out_valid) begin
        if (q2.size() == 0) check("d2_extra_out", 1, 0);
        else check("d2_data", bus2.out_data, q2.pop_front());
        got++;
      end
      if (done2) d2done++;
      bus2.io_rx_rd_valid = 1'b0;
      if (sent < 64) begin
        bus2.io_rx_rd_valid = 1'b1;
        bus2.io_rx_data     = line_of(58'h3_0000 + 58'(sent));
        sent++;
      end
    end
    check("d2_lines", got, 64);
    check("d2_done", d2done, 1);
    check("d2_ovf", ovf2, 0);

    // a line arriving while idle is dropped and flagged
    inject_cnt++;
    repeat (3) @(posedge clk);
    #1;
    check("ovf_set", ovf1, 1);
    check("ovf_out_valid", bus1.out_valid, 0);

    // reset with 5 lines outstanding, then a clean job
    resp_hold = 1'b1;
    start_job(58'h500, 32'd5);
    for (int i = 0; i < 20 && exp_req.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("mid_req_issued", exp_req.size(), 0);
    check("mid_busy", busy1, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_done", done1, 0);
    check("mid_rst_ovf", ovf1, 0);
    check("mid_rst_req_valid", bus1.cor_tx_rd_valid, 0);
    check("mid_rst_out_valid", bus1.out_valid, 0);
    check("mid_rst_out_data", bus1.out_data, 0);
    pending.delete();
    exp_data.delete();
    exp_req.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    resp_hold = 1'b0;
    c0 = done_cnt;
    start_job(58'h2000, 32'd12);
    wait_done(c0, "post_rst_done");
    check("post_rst_ovf", ovf1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
